// File: rtl/hazard_unit.sv
// Pipeline hazard controller for the 5-stage ARM pipeline: Execute-stage forwarding,
// load-use and PC-write stalls/flushes, and multi-cycle multiply sequencing.
module hazard_unit #(
    parameter int unsigned MUL_LAT = 3,
    parameter int unsigned CNT_W   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcD,
    input  logic       PCSrcE,
    input  logic       PCSrcM,
    input  logic       PCSrcW,
    input  logic       BranchTakenE,
    input  logic       MulStartE,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       FlushD,
    output logic       FlushE,
    output logic       MulBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        LAST = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mul_stall;
    logic             ldr_stall;
    logic             pc_wr_pending;
    logic [1:0]       fwd_a, fwd_b;

    // Memory-stage result beats Writeback; R15 is never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                           input logic       rw_m,
                                           input logic [3:0] wa_m,
                                           input logic       rw_w,
                                           input logic [3:0] wa_w);
        logic [1:0] sel;
        sel = 2'b00;
        if (ra != 4'hF) begin
            if (rw_m && (wa_m == ra)) begin
                sel = 2'b10;
            end else if (rw_w && (wa_w == ra)) begin
                sel = 2'b01;
            end
        end
        return sel;
    endfunction

    assign fwd_a = fwd_sel(RA1E, RegWriteM, WA3M, RegWriteW, WA3W);
    assign fwd_b = fwd_sel(RA2E, RegWriteM, WA3M, RegWriteW, WA3W);

    assign ldr_stall     = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    assign pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;

    // Multiply sequencer: the first cycle is seen in IDLE, so BUSY+LAST cover MUL_LAT-1 more.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        case (state_q)
            IDLE: begin
                if (MulStartE && (MUL_LAT > 1)) begin
                    mul_stall = 1'b1;
                    if (MUL_LAT >= 3) begin
                        cnt_d   = CNT_W'(MUL_LAT - 2);
                        state_d = BUSY;
                    end else begin
                        state_d = LAST;
                    end
                end
            end
            BUSY: begin
                mul_stall = 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = LAST;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LAST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Every output is forced low while reset is asserted.
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        MulBusy   = 1'b0;
        if (!reset) begin
            ForwardAE = fwd_a;
            ForwardBE = fwd_b;
            StallF    = ldr_stall || pc_wr_pending || mul_stall;
            StallD    = ldr_stall || mul_stall;
            StallE    = mul_stall;
            FlushD    = pc_wr_pending || PCSrcW || BranchTakenE;
            FlushE    = (ldr_stall || BranchTakenE) && !mul_stall;
            MulBusy   = (state_q != IDLE);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: three elaborations (MUL_LAT 3, 1, 2) share stimulus;
// a behavioural occupancy model predicts outputs, a monitor pops and compares each cycle.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE;

    logic [1:0] fa3, fb3, fa1, fb1, fa2, fb2;
    logic       sf3, sd3, se3, fd3, fe3, mb3;
    logic       sf1, sd1, se1, fd1, fe1, mb1;
    logic       sf2, sd2, se2, fd2, fe2, mb2;

    always #5 clk = ~clk;

    hazard_unit #(.MUL_LAT(3), .CNT_W(4)) u_dut3 (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .ForwardAE(fa3), .ForwardBE(fb3), .StallF(sf3), .StallD(sd3), .StallE(se3),
        .FlushD(fd3), .FlushE(fe3), .MulBusy(mb3));

    hazard_unit #(.MUL_LAT(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .ForwardAE(fa1), .ForwardBE(fb1), .StallF(sf1), .StallD(sd1), .StallE(se1),
        .FlushD(fd1), .FlushE(fe1), .MulBusy(mb1));

    hazard_unit #(.MUL_LAT(2), .CNT_W(4)) u_dut2 (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE), .MulStartE(MulStartE),
        .ForwardAE(fa2), .ForwardBE(fb2), .StallF(sf2), .StallD(sd2), .StallE(se2),
        .FlushD(fd2), .FlushE(fe2), .MulBusy(mb2));

    // Output vector layout: {ForwardAE, ForwardBE, StallF, StallD, StallE, FlushD, FlushE, MulBusy}
    logic [9:0] act3, act1, act2;
    assign act3 = {fa3, fb3, sf3, sd3, se3, fd3, fe3, mb3};
    assign act1 = {fa1, fb1, sf1, sd1, se1, fd1, fe1, mb1};
    assign act2 = {fa2, fb2, sf2, sd2, se2, fd2, fe2, mb2};

    typedef struct packed {
        logic       rst;
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwm, rww, m2r, pcd, pce, pcm, pcw, bt, mul;
    } stim_t;

    typedef struct packed {
        logic [9:0] l3, l1, l2;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   rem[3];
    int   lat[3] = '{3, 1, 2};

    function automatic logic [1:0] ref_fwd(input stim_t s, input logic [3:0] ra);
        if (ra == 4'hF)                  return 2'b00;
        if (s.rwm && (s.wa3m == ra))     return 2'b10;
        if (s.rww && (s.wa3w == ra))     return 2'b01;
        return 2'b00;
    endfunction

    // rem_in = cycles the in-flight multiply still owes E after the previous cycle.
    function automatic logic [9:0] ref_model(input stim_t s, input int l, input int rem_in,
                                             output int rem_out);
        int   cur;
        logic busy, stall, ldr, pend;
        if (s.rst) begin
            rem_out = 0;
            return 10'd0;
        end
        busy    = (rem_in > 0);
        cur     = busy ? rem_in : (s.mul ? l : 0);
        stall   = (cur > 1);
        rem_out = (cur > 0) ? cur - 1 : 0;
        ldr     = s.m2r && ((s.wa3e == s.ra1d) || (s.wa3e == s.ra2d));
        pend    = s.pcd || s.pce || s.pcm;
        return {ref_fwd(s, s.ra1e), ref_fwd(s, s.ra2e), ldr | pend | stall, ldr | stall,
                stall, pend | s.pcw | s.bt, (ldr | s.bt) & ~stall, busy};
    endfunction

    task automatic apply(input stim_t s);
        exp_t e;
        int   r;
        @(negedge clk);
        reset = s.rst; RA1D = s.ra1d; RA2D = s.ra2d; RA1E = s.ra1e; RA2E = s.ra2e;
        WA3E = s.wa3e; WA3M = s.wa3m; WA3W = s.wa3w; RegWriteM = s.rwm; RegWriteW = s.rww;
        MemtoRegE = s.m2r; PCSrcD = s.pcd; PCSrcE = s.pce; PCSrcM = s.pcm; PCSrcW = s.pcw;
        BranchTakenE = s.bt; MulStartE = s.mul;
        e.l3 = ref_model(s, lat[0], rem[0], r); rem[0] = r;
        e.l1 = ref_model(s, lat[1], rem[1], r); rem[1] = r;
        e.l2 = ref_model(s, lat[2], rem[2], r); rem[2] = r;
        q.push_back(e);
    endtask

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: outputs are valid every cycle once inputs have settled after the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                check("lat3", act3, e.l3);
                check("lat1", act1, e.l1);
                check("lat2", act2, e.l2);
            end
        end
    end

    function automatic logic [3:0] rreg();
        if ($urandom_range(0, 7) == 0) return 4'hF;
        return 4'($urandom_range(0, 3));
    endfunction

    initial begin
        stim_t s, z;
        z = '0;
        z.ra1d = 4'd10; z.ra2d = 4'd11; z.ra1e = 4'd12; z.ra2e = 4'd13;
        z.wa3e = 4'd7;  z.wa3m = 4'd8;  z.wa3w = 4'd9;
        rem = '{0, 0, 0};
        reset = 1'b1;
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE, PCSrcD, PCSrcE, PCSrcM, PCSrcW} = '0;
        {BranchTakenE, MulStartE} = '0;

        s = z; s.rst = 1'b1; s.mul = 1'b1; s.bt = 1'b1; s.pcd = 1'b1;
        apply(s); apply(s);

        // Forwarding priority and R15 exclusion
        s = z; s.rwm = 1'b1; s.wa3m = 4'd3; s.ra1e = 4'd3; s.rww = 1'b1; s.wa3w = 4'd3;
        apply(s);
        s.rwm = 1'b0; apply(s);
        s.rwm = 1'b1; s.ra1e = 4'hF; s.ra2e = 4'hF; s.wa3m = 4'hF; s.wa3w = 4'hF; apply(s);

        // Load-use hit then miss
        s = z; s.m2r = 1'b1; s.wa3e = 4'd5; s.ra2d = 4'd5; apply(s);
        s.wa3e = 4'd6; apply(s);

        // PC write walking down the pipe, then a lone taken branch
        s = z; s.pcd = 1'b1; apply(s);
        s = z; s.pce = 1'b1; apply(s);
        s = z; s.pcm = 1'b1; apply(s);
        s = z; s.pcw = 1'b1; apply(s);
        apply(z);
        s = z; s.bt = 1'b1; apply(s);
        s = z; s.bt = 1'b1; s.m2r = 1'b1; s.wa3e = 4'd10; apply(s);

        // Multiply held for three cycles with a branch in the middle cycle
        s = z; s.mul = 1'b1; apply(s);
        s.bt = 1'b1; apply(s);
        s.bt = 1'b0; apply(s);
        apply(z); apply(z);

        // Reset in a BUSY cycle, multiply request still asserted afterwards
        s = z; s.mul = 1'b1; apply(s);
        s.rst = 1'b1; apply(s);
        s.rst = 1'b0; apply(s); apply(s); apply(s);
        apply(z);

        for (int i = 0; i < 500; i++) begin
            s.rst  = ($urandom_range(0, 49) == 0);
            s.ra1d = rreg(); s.ra2d = rreg(); s.ra1e = rreg(); s.ra2e = rreg();
            s.wa3e = rreg(); s.wa3m = rreg(); s.wa3w = rreg();
            s.rwm  = 1'($urandom_range(0, 1)); s.rww = 1'($urandom_range(0, 1));
            s.m2r  = ($urandom_range(0, 3) == 0);
            s.pcd  = ($urandom_range(0, 9) == 0); s.pce = ($urandom_range(0, 9) == 0);
            s.pcm  = ($urandom_range(0, 9) == 0); s.pcw = ($urandom_range(0, 9) == 0);
            s.bt   = ($urandom_range(0, 7) == 0);
            s.mul  = ($urandom_range(0, 2) == 0);
            apply(s);
        end

        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
